// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline stall/flush
// sequencer and its hazard-detection helper.
//   state_e     : sequencer FSM state encoding (2 bits)
//   RESULT_LOAD : ResultSrcE encoding that marks a load in Execute
//   REG_ZERO    : x0, never a real data dependency
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: bundle of hazard inputs, memory handshake and the
// per-stage enable/flush outputs exchanged between the datapath and the
// stall/flush sequencer.
//   master : datapath side (drives hazard/handshake inputs, receives controls)
//   slave  : sequencer side (pipeline_ctrl)
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;
  logic             FEN;
  logic             DEN;
  logic             EEN;
  logic             MEN;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  FEN, DEN, EEN, MEN, FlushD, FlushE, FlushW, MemErr, StallCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output FEN, DEN, EEN, MEN, FlushD, FlushE, FlushW, MemErr, StallCnt
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
//   rs1_d, rs2_d  : source registers of the Decode instruction
//   rd_e          : destination register of the Execute instruction
//   result_src_e  : Execute result select (load = RESULT_LOAD)
//   lw_stall      : Decode needs a value the Execute load has not produced yet
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  output logic       lw_stall
);

  always_comb begin
    lw_stall = (result_src_e == RESULT_LOAD) && (rd_e != REG_ZERO) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : hazard inputs, memory req/ready handshake, stage enables,
//              flushes, sticky MemErr and saturating StallCnt
// Parameters: TIMEOUT (1..255) wait cycles before a memory access is
// declared hung; CNT_W width of the stall-cycle counter.
//
// state | meaning
// IDLE  | no memory access outstanding
// WAIT  | memory access outstanding, counting not-ready cycles
// ERR   | access exceeded TIMEOUT, pipeline frozen until rst
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_if.slave   bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall;
  logic mem_stall;
  logic fen, den, een, men;
  logic flush_d, flush_e, flush_w;
  logic mem_err;

  hazard_detect u_hazard_detect (
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .rd_e         (bus.RdE),
    .result_src_e (bus.ResultSrcE),
    .lw_stall     (lw_stall)
  );

  assign mem_stall = bus.MemReqM & ~bus.MemReadyM;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (mem_stall) state_d = WAIT;
      end
      WAIT: begin
        // Ready on the timeout edge still completes the access.
        if (bus.MemReadyM) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) state_d = ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Enables/flushes are combinational so the stage registers react on the
  // very next edge.
  always_comb begin
    fen     = 1'b1;
    den     = 1'b1;
    een     = 1'b1;
    men     = 1'b1;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    mem_err = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (state_q == ERR) begin
      fen     = 1'b0;
      den     = 1'b0;
      een     = 1'b0;
      men     = 1'b0;
      mem_err = 1'b1;
    end else if (mem_stall) begin
      // D and E are held, so branch/load-use are re-evaluated after release.
      fen     = 1'b0;
      den     = 1'b0;
      een     = 1'b0;
      men     = 1'b0;
      flush_w = 1'b1;
    end else if (bus.PCSrcE) begin
      // Decode holds a wrong-path instruction; its load-use hazard is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      fen     = 1'b0;
      den     = 1'b0;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!fen && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.FEN      = fen;
  assign bus.DEN      = den;
  assign bus.EEN      = een;
  assign bus.MEN      = men;
  assign bus.FlushD   = flush_d;
  assign bus.FlushE   = flush_e;
  assign bus.FlushW   = flush_w;
  assign bus.MemErr   = mem_err;
  assign bus.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl with
// TIMEOUT=4 and a 4-bit stall counter.
module tb_pipeline_ctrl;

  // {FEN,DEN,EEN,MEN,FlushD,FlushE,FlushW,MemErr}
  localparam logic [7:0] O_RUN = 8'b1111_0000;
  localparam logic [7:0] O_RST = 8'b1111_1110;
  localparam logic [7:0] O_LW  = 8'b0011_0100;
  localparam logic [7:0] O_BR  = 8'b1111_1100;
  localparam logic [7:0] O_MEM = 8'b0000_0010;
  localparam logic [7:0] O_ERR = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_out(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {bus.FEN, bus.DEN, bus.EEN, bus.MEN,
           bus.FlushD, bus.FlushE, bus.FlushW, bus.MemErr};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (bus.StallCnt === exp) else begin
      errors++;
      $error("FAIL %s: observed StallCnt=%0d expected=%0d", tag, bus.StallCnt, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Rs1D       = 5'd0;
    bus.Rs2D       = 5'd0;
    bus.RdE        = 5'd0;
    bus.ResultSrcE = 2'b00;
    bus.PCSrcE     = 1'b0;
    bus.MemReqM    = 1'b0;
    bus.MemReadyM  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk_out("reset_outs", O_RST);
    chk_cnt("reset_cnt", 4'd0);

    rst = 1'b0;
    #1;
    chk_out("run_after_reset", O_RUN);

    // load-use on Rs1D
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
    #1; chk_out("lw_rs1", O_LW);
    tick();
    idle_inputs();
    #1; chk_out("lw_one_bubble", O_RUN);
    chk_cnt("lw_cnt", 4'd1);

    // load to x0 is not a hazard
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    #1; chk_out("lw_x0", O_RUN);
    tick();
    chk_cnt("lw_x0_cnt", 4'd1);

    // load-use on Rs2D
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd9; bus.Rs1D = 5'd3; bus.Rs2D = 5'd9;
    #1; chk_out("lw_rs2", O_LW);
    tick();
    chk_cnt("lw_rs2_cnt", 4'd2);

    // non-load with matching registers
    bus.ResultSrcE = 2'b00;
    #1; chk_out("alu_no_stall", O_RUN);
    tick();

    // taken branch suppresses load-use
    bus.PCSrcE = 1'b1; bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1; chk_out("br_over_lw", O_BR);
    tick();
    idle_inputs();
    chk_cnt("br_cnt", 4'd2);

    // memory access with 3 not-ready cycles
    bus.MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk_out("mem_wait", O_MEM);
      tick();
    end
    bus.MemReadyM = 1'b1;
    #1; chk_out("mem_ready_release", O_RUN);
    chk_cnt("mem_cnt", 4'd5);
    tick();
    idle_inputs();
    #1; chk_out("mem_after", O_RUN);

    // zero-wait access
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
    #1; chk_out("mem_zero_wait", O_RUN);
    tick();
    chk_cnt("mem_zero_cnt", 4'd5);

    // branch during memory wait
    bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; chk_out("br_in_mem_wait", O_MEM);
      tick();
    end
    bus.MemReadyM = 1'b1;
    #1; chk_out("br_after_ready", O_BR);
    tick();
    idle_inputs();
    chk_cnt("br_mem_cnt", 4'd7);

    // timeout: 1 IDLE cycle + 4 WAIT cycles, then ERR
    bus.MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; chk_out("to_wait", O_MEM);
      tick();
    end
    chk_out("to_err", O_ERR);
    chk_cnt("to_cnt", 4'd12);
    tick();
    bus.MemReadyM = 1'b1;
    #1; chk_out("err_ignores_ready", O_ERR);
    tick();
    tick();
    tick();
    chk_out("err_sticky", O_ERR);
    chk_cnt("err_cnt_sat", 4'd15);

    // reset out of ERR
    rst = 1'b1;
    #1; chk_out("rst_in_err", O_RST);
    tick();
    chk_cnt("rst_err_cnt", 4'd0);
    rst = 1'b0;
    idle_inputs();
    #1; chk_out("run_after_err", O_RUN);

    // reset mid-WAIT
    bus.MemReqM = 1'b1;
    tick();
    tick();
    chk_cnt("midwait_cnt", 4'd2);
    rst = 1'b1;
    #1; chk_out("rst_mid_wait", O_RST);
    tick();
    chk_cnt("rst_mid_wait_cnt", 4'd0);
    rst = 1'b0;
    #1; chk_out("restall_after_rst", O_MEM);
    tick();
    bus.MemReadyM = 1'b1;
    #1; chk_out("release_after_rst", O_RUN);
    tick();
    idle_inputs();
    chk_cnt("after_rst_cnt", 4'd1);

    // counter saturation with 20 load-use stall cycles
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
    for (int i = 0; i < 13; i++) tick();
    chk_cnt("sat_14", 4'd14);
    for (int i = 0; i < 7; i++) tick();
    chk_cnt("sat_15", 4'd15);
    chk_out("sat_still_lw", O_LW);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the execute-stage forwarding/hazard logic and drives the per-stage register enables and flushes. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory accesses through a req/ready handshake. It also detects hung memory accesses and counts stall cycles for performance monitoring.

## Interface
Parameters:
- TIMEOUT, 255: max consecutive wait cycles on one memory access before error; 1..255.
- CNT_W, 32: stall-cycle counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1D  in  5  source register 1 of instruction in Decode.
- Rs2D  in  5  source register 2 of instruction in Decode.
- RdE  in  5  destination register of instruction in Execute.
- ResultSrcE  in  2  result select in Execute; 2'b01 = load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MemReqM  in  1  Memory-stage instruction accesses data memory.
- MemReadyM  in  1  data memory completes access this cycle.
- FEN  out  1  Fetch (PC) register enable, active-high.
- DEN  out  1  Decode register enable.
- EEN  out  1  Execute register enable.
- MEN  out  1  Memory register enable.
- FlushD  out  1  clear Decode register to bubble.
- FlushE  out  1  clear Execute register to bubble.
- FlushW  out  1  clear Writeback register to bubble.
- MemErr  out  1  sticky: memory access exceeded TIMEOUT.
- StallCnt  out  CNT_W  cycles with FEN=0, saturating.

## Operation
- Combinational terms:
  - memStall = MemReqM & !MemReadyM.
  - lwStall = (ResultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- FSM states:
  - IDLE: no memory wait. memStall -> WAIT; else stay.
  - WAIT: memory access outstanding. MemReadyM -> IDLE; wait counter reaching TIMEOUT -> ERR.
  - ERR: terminal. Leaves only on rst.
- Output priority, highest first:
  - ERR: all enables 0, all flushes 0, MemErr=1. Pipeline frozen.
  - memStall (IDLE or WAIT): FEN=DEN=EEN=MEN=0, FlushW=1, FlushD=FlushE=0. PCSrcE and lwStall are ignored this cycle; they are re-evaluated once the pipeline advances, because E and D are held.
  - PCSrcE: FlushD=1, FlushE=1, all enables 1. lwStall is suppressed because the D instruction is wrong-path.
  - lwStall: FEN=DEN=0, FlushE=1, EEN=MEN=1.
  - Otherwise: all enables 1, all flushes 0.
- Wait counter:
  - 8-bit; cleared in IDLE.
  - Increments each WAIT cycle with MemReadyM=0.
  - WAIT->ERR when counter==TIMEOUT-1 and MemReadyM=0 on that edge.
- StallCnt:
  - Increments on every cycle where FEN=0, including ERR.
  - Holds at 2^CNT_W-1.
- Zero-wait access (MemReqM & MemReadyM in IDLE): no stall, stay IDLE.

## Timing
- All enable/flush outputs are combinational from state and current inputs. Zero-cycle latency to the stage registers on the next edge.
- Memory handshake:
  - MemReqM must stay high while MEN=0; the instruction is held in M.
  - The ready cycle completes the access: enables return to 1 in that same cycle, and state returns to IDLE on the next edge.
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 bubbles. A memory access with N not-ready cycles costs N stall cycles.
- Reset (rst=1 at edge):
  - state=IDLE, wait counter=0, StallCnt=0, MemErr=0.
  - While rst is high, outputs are forced: enables 1, FlushD=FlushE=FlushW=1, MemErr=0.
- rst asserted mid-WAIT or in ERR: same as above. Any outstanding handshake is abandoned; the memory side resets on the same rst.
- Simultaneous MemReadyM and timeout edge: ready wins, go IDLE.

## Structure
- Shared package pipeline_pkg:
  - state enum (IDLE, WAIT, ERR) as a 2-bit typedef.
  - RESULT_LOAD = 2'b01.
  - REG_ZERO = 5'd0.
- One natural sub-module, hazard_detect: purely combinational lwStall computation, reusable by the forwarding logic.
- FSM, counters and output priority stay in pipeline_ctrl.

## Test plan
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5, no mem/branch -> FEN=DEN=0, FlushE=1, EEN=MEN=1 for 1 cycle, StallCnt +1. Repeat with RdE=0 -> no stall.
- Taken branch plus simultaneous lwStall: PCSrcE=1, ResultSrcE=01, RdE=Rs2D=7 -> FlushD=FlushE=1, all enables 1, StallCnt unchanged.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high -> enables 0 and FlushW=1 for exactly 3 cycles, release in cycle 4, state IDLE after, StallCnt=3. Zero-wait case: no stall.
- Branch during memory wait: PCSrcE=1 with memStall -> only the memory stall pattern. After ready, if PCSrcE is still high -> FlushD=FlushE=1.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> ERR after 4 WAIT cycles, MemErr=1 sticky, all enables/flushes 0. Ready arriving later has no effect. rst -> MemErr=0, state IDLE.
- Reset mid-WAIT and counter saturation: rst during WAIT -> StallCnt=0, flushes 1 while rst is high. With CNT_W=4, 20 stall cycles -> StallCnt=15.
